ram_rd_controller: RTL and testbench

- Read-side controller for the ping-pong sample RAM pair (ram_0/ram_1, 1024 x DATA_W each).
- While the write controller fills one bank, this block streams the other, already-full bank out in address order 0..DEPTH-1 toward the FFT input.
- It generates the per-bank read enables and the shared read address, muxes the bank outputs, and emits a framed stream: valid, first, last.
- It queues one pending bank-ready request and flags overruns.

---
 rtl/ram_ctrl_pkg.sv | 22 ++
 rtl/CU_ram_rd_controller.sv | 97 +++++++++
 rtl/datapath_ram_rd_controller.sv | 77 +++++++
 rtl/ram_rd_controller.sv | 68 ++++++
 tb/tb_ram_rd_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// Constants and types shared by the ping-pong RAM read and write controllers.
package ram_ctrl_pkg;

   localparam int DEPTH   = 1024;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 16;
   localparam int RAM_LAT = 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   // One slot of the read-latency pipeline: framing travels alongside the RAM access.
   typedef struct packed {
      logic valid;
      logic bank;
      logic first;
      logic last;
   } pipe_t;

endpackage

// File: rtl/CU_ram_rd_controller.sv
// Control unit: frame FSM, one-deep pending bank request, overrun pulse, ready/busy.
module CU_ram_rd_controller
   import ram_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic sel_ram,
   input  logic tc,
   output logic sclr_cnt,
   output logic en_cnt,
   output logic bank,
   output logic busy,
   output logic ready,
   output logic overrun
);

   state_t state_r, state_s;
   logic   bank_r, bank_s;
   logic   pend_full_r, pend_full_s;
   logic   pend_bank_r, pend_bank_s;
   logic   overrun_r, overrun_s;

   // State and control registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         bank_r      <= 1'b0;
         pend_full_r <= 1'b0;
         pend_bank_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         bank_r      <= bank_s;
         pend_full_r <= pend_full_s;
         pend_bank_r <= pend_bank_s;
         overrun_r   <= overrun_s;
      end
   end

   // Next state, pending queue and counter control.
   always_comb begin
      state_s     = state_r;
      bank_s      = bank_r;
      pend_full_s = pend_full_r;
      pend_bank_s = pend_bank_r;
      overrun_s   = 1'b0;
      sclr_cnt    = 1'b0;
      en_cnt      = 1'b0;
      case (state_r)
         IDLE: begin
            sclr_cnt = 1'b1;
            if (start) begin
               bank_s  = sel_ram;
               state_s = READ;
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            en_cnt = 1'b1;
            if (tc) begin
               sclr_cnt = 1'b1;
               if (pend_full_r) begin
                  // Queued frame wins; a start arriving now has nowhere to go.
                  bank_s      = pend_bank_r;
                  pend_full_s = 1'b0;
                  overrun_s   = start;
               end else if (start) begin
                  bank_s = sel_ram;
               end else begin
                  state_s = IDLE;
               end
            end else if (start) begin
               if (pend_full_r) begin
                  overrun_s = 1'b1;
               end else begin
                  pend_full_s = 1'b1;
                  pend_bank_s = sel_ram;
               end
            end else begin
               state_s = READ;
            end
         end
         default: begin
            state_s     = IDLE;
            pend_full_s = 1'b0;
         end
      endcase
   end

   assign bank    = bank_r;
   assign busy    = (state_r == READ);
   assign ready   = ~pend_full_r;
   assign overrun = overrun_r;

endmodule

// File: rtl/datapath_ram_rd_controller.sv
// Datapath: read address counter, per-bank read enables, RAM-latency framing pipeline and output mux.
module datapath_ram_rd_controller
   import ram_ctrl_pkg::pipe_t;
#(
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 16,
   parameter int RAM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sclr_cnt,
   input  logic              en_cnt,
   input  logic              bank,
   input  logic [DATA_W-1:0] din_ram_0,
   input  logic [DATA_W-1:0] din_ram_1,
   output logic              tc_cnt,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_en_ram_0,
   output logic              rd_en_ram_1,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              first,
   output logic              last
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] addr_r;
   pipe_t             pipe_r [RAM_LAT];
   pipe_t             issue_s;
   pipe_t             out_s;

   // Address counter; clear has priority so the wrap at the terminal count stays in range.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_r <= {ADDR_W{1'b0}};
      end else if (sclr_cnt) begin
         addr_r <= {ADDR_W{1'b0}};
      end else if (en_cnt) begin
         addr_r <= addr_r + ADDR_W'(1);
      end else begin
         addr_r <= addr_r;
      end
   end

   assign tc_cnt      = (addr_r == LAST_ADDR);
   assign addr        = addr_r;
   assign rd_en_ram_0 = en_cnt & ~bank;
   assign rd_en_ram_1 = en_cnt & bank;

   assign issue_s.valid = en_cnt;
   assign issue_s.bank  = bank;
   assign issue_s.first = en_cnt & (addr_r == {ADDR_W{1'b0}});
   assign issue_s.last  = en_cnt & tc_cnt;

   // Framing pipeline matched to the RAM read latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            pipe_r[i] <= '{valid: 1'b0, bank: 1'b0, first: 1'b0, last: 1'b0};
         end
      end else begin
         pipe_r[0] <= issue_s;
         for (int i = 1; i < RAM_LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign out_s      = pipe_r[RAM_LAT-1];
   assign dout_valid = out_s.valid;
   assign first      = out_s.first;
   assign last       = out_s.last;
   assign dout       = out_s.valid ? (out_s.bank ? din_ram_1 : din_ram_0) : {DATA_W{1'b0}};

endmodule

// File: rtl/ram_rd_controller.sv
// Read-side controller for the ping-pong sample RAM pair: streams a full bank out as a framed sample stream.
module ram_rd_controller #(
   parameter int DEPTH   = ram_ctrl_pkg::DEPTH,
   parameter int ADDR_W  = ram_ctrl_pkg::ADDR_W,
   parameter int DATA_W  = ram_ctrl_pkg::DATA_W,
   parameter int RAM_LAT = ram_ctrl_pkg::RAM_LAT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              sel_ram,
   output logic              rd_en_ram_0,
   output logic              rd_en_ram_1,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din_ram_0,
   input  logic [DATA_W-1:0] din_ram_1,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              first,
   output logic              last,
   output logic              busy,
   output logic              ready,
   output logic              overrun
);

   logic sclr_cnt;
   logic en_cnt;
   logic tc_cnt;
   logic bank;

   CU_ram_rd_controller u_cu (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .sel_ram  (sel_ram),
      .tc       (tc_cnt),
      .sclr_cnt (sclr_cnt),
      .en_cnt   (en_cnt),
      .bank     (bank),
      .busy     (busy),
      .ready    (ready),
      .overrun  (overrun)
   );

   datapath_ram_rd_controller #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .RAM_LAT (RAM_LAT)
   ) u_dp (
      .clock       (clock),
      .reset       (reset),
      .sclr_cnt    (sclr_cnt),
      .en_cnt      (en_cnt),
      .bank        (bank),
      .din_ram_0   (din_ram_0),
      .din_ram_1   (din_ram_1),
      .tc_cnt      (tc_cnt),
      .addr        (addr),
      .rd_en_ram_0 (rd_en_ram_0),
      .rd_en_ram_1 (rd_en_ram_1),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .first       (first),
      .last        (last)
   );

endmodule

// File: tb/tb_ram_rd_controller.sv
// Bench for ram_rd_controller: RAM_LAT=1 and RAM_LAT=3 builds driven in lockstep against a frame-level model.
module tb_ram_rd_controller;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;

   typedef struct {
      bit                v;
      bit                b;
      logic [ADDR_W-1:0] a;
   } issue_t;

   logic clock = 1'b0;
   logic reset;
   logic start;
   logic sel_ram;

   logic              rd0_a, rd1_a, val_a, fst_a, lst_a, busy_a, rdy_a, ovr_a;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] dout_a, din0_a, din1_a;
   logic              rd0_b, rd1_b, val_b, fst_b, lst_b, busy_b, rdy_b, ovr_b;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] dout_b;
   logic [DATA_W-1:0] d0_b [3];
   logic [DATA_W-1:0] d1_b [3];

   logic [DATA_W-1:0] mem0 [DEPTH];
   logic [DATA_W-1:0] mem1 [DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   // Frame-level model: reads left in the current frame, its bank, a one-deep start queue.
   int     rd_left;
   bit     cur_bank;
   bit     pend [$];
   bit     ovr_exp;
   issue_t hist [$];

   int lasts_a, lasts_b, vcnt_a, vcnt_b, ovr_cnt;

   ram_rd_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(1)) dut_a (
      .clock(clock), .reset(reset), .start(start), .sel_ram(sel_ram),
      .rd_en_ram_0(rd0_a), .rd_en_ram_1(rd1_a), .addr(addr_a),
      .din_ram_0(din0_a), .din_ram_1(din1_a), .dout(dout_a), .dout_valid(val_a),
      .first(fst_a), .last(lst_a), .busy(busy_a), .ready(rdy_a), .overrun(ovr_a)
   );

   ram_rd_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(3)) dut_b (
      .clock(clock), .reset(reset), .start(start), .sel_ram(sel_ram),
      .rd_en_ram_0(rd0_b), .rd_en_ram_1(rd1_b), .addr(addr_b),
      .din_ram_0(d0_b[2]), .din_ram_1(d1_b[2]), .dout(dout_b), .dout_valid(val_b),
      .first(fst_b), .last(lst_b), .busy(busy_b), .ready(rdy_b), .overrun(ovr_b)
   );

   always #5 clock = ~clock;

   // Behavioural RAMs: one-cycle and three-cycle read latency.
   always @(posedge clock) begin
      if (rd0_a) din0_a <= mem0[addr_a];
      if (rd1_a) din1_a <= mem1[addr_a];
      if (rd0_b) d0_b[0] <= mem0[addr_b];
      if (rd1_b) d1_b[0] <= mem1[addr_b];
      d0_b[1] <= d0_b[0];
      d0_b[2] <= d0_b[1];
      d1_b[1] <= d1_b[0];
      d1_b[2] <= d1_b[1];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_out(input issue_t e);
      logic [DATA_W-1:0] d;
      d = e.v ? (e.b ? mem1[e.a] : mem0[e.a]) : 16'h0000;
      return {13'b0, e.v, e.v && (e.a == 10'd0), e.v && (e.a == ADDR_W'(DEPTH - 1)), d};
   endfunction

   task automatic reset_model();
      rd_left  = 0;
      cur_bank = 1'b0;
      ovr_exp  = 1'b0;
      pend.delete();
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back('{v: 1'b0, b: 1'b0, a: 10'd0});
   endtask

   task automatic clear_counts();
      lasts_a = 0; lasts_b = 0; vcnt_a = 0; vcnt_b = 0; ovr_cnt = 0;
   endtask

   // One clock: check outputs at the falling edge, drive the next inputs, advance the model.
   task automatic step(input bit st, input bit sel);
      logic [4:0]        ctrl_e;
      logic [ADDR_W-1:0] addr_e;
      issue_t            cur;
      @(negedge clock);
      ctrl_e = {rd_left > 0 && !cur_bank, rd_left > 0 && cur_bank, rd_left > 0, pend.size() == 0, ovr_exp};
      addr_e = (rd_left > 0) ? ADDR_W'(DEPTH - rd_left) : 10'd0;
      check_val("ctrl_lat1", {27'b0, rd0_a, rd1_a, busy_a, rdy_a, ovr_a}, {27'b0, ctrl_e});
      check_val("ctrl_lat3", {27'b0, rd0_b, rd1_b, busy_b, rdy_b, ovr_b}, {27'b0, ctrl_e});
      check_val("addr_lat1", {22'b0, addr_a}, {22'b0, addr_e});
      check_val("addr_lat3", {22'b0, addr_b}, {22'b0, addr_e});
      check_val("out_lat1", {13'b0, val_a, fst_a, lst_a, dout_a}, exp_out(hist[0]));
      check_val("out_lat3", {13'b0, val_b, fst_b, lst_b, dout_b}, exp_out(hist[2]));
      if (lst_a) lasts_a++;
      if (lst_b) lasts_b++;
      if (val_a) vcnt_a++;
      if (val_b) vcnt_b++;
      if (ovr_a) ovr_cnt++;
      cur = '{v: rd_left > 0, b: cur_bank, a: addr_e};
      hist.push_front(cur);
      void'(hist.pop_back());
      start   = st;
      sel_ram = sel;
      ovr_exp = 1'b0;
      if (st) begin
         if (pend.size() == 0) pend.push_back(sel);
         else ovr_exp = 1'b1;
      end
      if (rd_left > 0) rd_left--;
      if (rd_left == 0 && pend.size() > 0) begin
         cur_bank = pend.pop_front();
         rd_left  = DEPTH;
      end
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ctrl_lat1"}, {24'b0, rd0_a, rd1_a, busy_a, rdy_a, ovr_a, val_a, fst_a, lst_a}, 32'h10);
      check_val({tag, "_ctrl_lat3"}, {24'b0, rd0_b, rd1_b, busy_b, rdy_b, ovr_b, val_b, fst_b, lst_b}, 32'h10);
      check_val({tag, "_data"}, {addr_a, addr_b, 12'b0}, 32'h0);
      check_val({tag, "_dout"}, {dout_a, dout_b}, 32'h0);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      sel_ram = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem0[i] = DATA_W'($urandom);
         mem1[i] = DATA_W'(i + 16'h0100);
      end
      reset_model();
      #12;
      check_reset_outputs("reset");
      @(negedge clock);
      reset = 1'b0;
      idle_steps(3);

      // Single frame from bank 1.
      clear_counts();
      step(1'b1, 1'b1);
      idle_steps(DEPTH + 6);
      check_val("single_lasts_lat1", lasts_a, 32'd1);
      check_val("single_lasts_lat3", lasts_b, 32'd1);
      check_val("single_samples", vcnt_a, DEPTH);

      // Back-to-back: second start at cycle 500 of the first frame.
      clear_counts();
      step(1'b1, 1'b0);
      for (int i = 1; i < 2 * DEPTH + 8; i++) step(i == 500, 1'b1);
      check_val("b2b_lasts_lat1", lasts_a, 32'd2);
      check_val("b2b_samples_lat3", vcnt_b, 2 * DEPTH);

      // Start exactly on the terminal-count cycle.
      clear_counts();
      step(1'b1, 1'b0);
      for (int g = 0; g < DEPTH && rd_left != 1; g++) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      idle_steps(DEPTH + 6);
      check_val("tc_lasts", lasts_a, 32'd2);
      check_val("tc_overruns", ovr_cnt, 32'd0);

      // Overrun: two starts during a frame, second one dropped.
      clear_counts();
      step(1'b1, 1'b0);
      idle_steps(100);
      step(1'b1, 1'b1);
      idle_steps(50);
      step(1'b1, 1'b0);
      idle_steps(2 * DEPTH);
      check_val("ovr_lasts", lasts_b, 32'd2);
      check_val("ovr_pulses", ovr_cnt, 32'd1);

      // Reset in the middle of a frame at address 300.
      step(1'b1, 1'b1);
      for (int g = 0; g < DEPTH && rd_left != DEPTH - 300; g++) step(1'b0, 1'b0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      start = 1'b0;
      reset_model();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      clear_counts();
      idle_steps(4);
      step(1'b1, 1'b0);
      idle_steps(DEPTH + 6);
      check_val("post_reset_lasts", lasts_a, 32'd1);
      check_val("post_reset_samples", vcnt_b, DEPTH);

      // Random starts and bank selections.
      for (int i = 0; i < 6000; i++) step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)));
      idle_steps(2 * DEPTH + 8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
